fifo_rr_arbiter: RTL

- Round-robin controller that drains N_IN input FIFOs (DATA_W-wide, depth 8, registered read data) into one output FIFO.
- Sequences pop on the selected input, then push of the popped word on the output one cycle later.
- Throttled by the output FIFO's almost_full/full flags.
- Sits between the per-lane TLP input FIFOs and the shared output FIFO; the FIFOs' error flags drive an ERROR state.

---
 rtl/fifo_rr_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of N_IN input FIFOs into one output FIFO.
// Each grant pops one input FIFO. The popped word is pushed to the output
// FIFO on the next cycle, because the input FIFO read data is registered.
// Popping stops while the output FIFO reports almost_full or full.
// Any FIFO error flag moves the FSM into a sticky ERROR state.
// Optional feature: define ARB_STATS_EN to add per-input 8-bit saturating
// grant counters on the grant_cnt port.
module fifo_rr_arbiter #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          in_empty,
    input  logic [N_IN-1:0]          in_error,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [N_IN-1:0]          in_pop,
    input  logic                     out_full,
    input  logic                     out_almost_full,
    input  logic                     out_error,
    output logic                     out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               state,
`ifdef ARB_STATS_EN
    output logic [N_IN*8-1:0]        grant_cnt,
`endif
    output logic                     error_out
);

    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;   // most recently granted input
    logic [IDX_W-1:0]   idx_q, idx_d;     // input popped last cycle
    logic               vld_q, vld_d;     // a pop happened last cycle
    logic [DATA_W-1:0]  data_q, data_d;   // last word pushed, held between pushes

    logic               any_err;
    logic               all_empty;
    logic               can_pop;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand_idx;

    // Wraps base+off into the range 0..N_IN-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = (base + off) % N_IN;
        return s[IDX_W-1:0];
    endfunction

    assign any_err   = (|in_error) | out_error;
    assign all_empty = &in_empty;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. ERROR wins over every other transition once
    // the FSM has left RESET/INIT, and it is only left through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
                if (any_err)         state_d = ST_ERROR;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)                  state_d = ST_ERROR;
                else if (all_empty && !vld_q) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    // FSM outputs.
    always_comb begin
        state     = state_q;
        error_out = (state_q == ST_ERROR);
    end

    // Round-robin grant. The scan starts just after the last grant. The input
    // popped in the previous cycle is skipped because its registered empty
    // flag does not yet reflect that pop.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand_idx  = last_q;
        in_pop    = '0;
        can_pop   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                    !out_full && !out_almost_full;
        for (int k = 1; k <= N_IN; k++) begin
            cand_idx = wrap_idx(int'(last_q), k);
            if (can_pop && !grant_vld && !in_empty[cand_idx] &&
                !(vld_q && (idx_q == cand_idx))) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_vld) begin
            in_pop[grant_idx] = 1'b1;
        end
    end

    // Push side: the word popped last cycle is now on the FIFO's q_b. A push
    // that is pending when ERROR is entered is dropped.
    always_comb begin
        out_push = vld_q && (state_q != ST_ERROR);
        out_data = out_push ? in_data[int'(idx_q)*DATA_W +: DATA_W] : data_q;
        data_d   = out_data;
        vld_d    = grant_vld;
        idx_d    = grant_vld ? grant_idx : idx_q;
        last_d   = grant_vld ? grant_idx : last_q;
    end

    // Grant pointer and pop->push pipeline registers. The pointer resets to
    // the last input so that input 0 has first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= IDX_W'(N_IN - 1);
            idx_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            last_q <= last_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [N_IN*8-1:0] cnt_q, cnt_d;

    // Per-input grant counters; they saturate at 255 and freeze in ERROR.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (in_pop[i] && (state_q != ST_ERROR) && (cnt_q[i*8 +: 8] != 8'hFF)) begin
                cnt_d[i*8 +: 8] = cnt_q[i*8 +: 8] + 8'd1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
